// File: rtl/poli_apb_arbiter.sv
// poli_apb_arbiter: round-robin arbiter plus APB master sharing one APB
// slave port between NREQ single-word requesters. One transfer is in flight
// at a time; a watchdog converts a slave that never raises PREADY into an
// error response. DATA_W defaults to the POLI word size (32).
module poli_apb_arbiter #(
  parameter int NREQ    = 2,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ-1:0]        req_write,
  input  logic [NREQ*DATA_W-1:0] req_addr,
  input  logic [NREQ*DATA_W-1:0] req_wdata,
  output logic [NREQ-1:0]        req_ready,
  output logic [NREQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]      rsp_rdata,
  output logic                   rsp_err,
  output logic                   PSEL,
  output logic                   PENABLE,
  output logic                   PWRITE,
  output logic [DATA_W-1:0]      PADDR,
  output logic [DATA_W-1:0]      PWDATA,
  input  logic [DATA_W-1:0]      PRDATA,
  input  logic                   PREADY
);

  localparam int IDX_W  = $clog2(NREQ);
  localparam int TCNT_W = $clog2(TIMEOUT) + 1;
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t             state;
  logic [IDX_W-1:0]   last;
  logic [IDX_W-1:0]   gidx;
  logic [TCNT_W-1:0]  tcnt;
  logic [DATA_W-1:0]  rdata_q;
  logic               err_q;

  logic               grant_any;
  logic [IDX_W-1:0]   grant_idx;
  logic [DATA_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wdata;
  logic               sel_write;

  // Round-robin search starting just after the last winner; scanning from the
  // far end downward lets the nearest pending requester overwrite the rest.
  always_comb begin
    int idx;
    idx       = 0;
    grant_any = 1'b0;
    grant_idx = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = (int'(last) + k) % NREQ;
      if (req_valid[idx]) begin
        grant_any = 1'b1;
        grant_idx = IDX_W'(idx);
      end
    end
  end

  // Request fields of the candidate winner, sampled only in the accept cycle.
  always_comb begin
    sel_addr  = req_addr[int'(grant_idx)*DATA_W +: DATA_W];
    sel_wdata = req_wdata[int'(grant_idx)*DATA_W +: DATA_W];
    sel_write = req_write[grant_idx];
  end

  // Accept pulse in IDLE; held low while reset is asserted so every output is 0.
  always_comb begin
    req_ready = '0;
    if (nRST && (state == IDLE) && grant_any) req_ready[grant_idx] = 1'b1;
  end

  // Response is visible only in RESP; data and error are forced to 0 otherwise.
  always_comb begin
    rsp_valid = '0;
    rsp_rdata = '0;
    rsp_err   = 1'b0;
    if (state == RESP) begin
      rsp_valid[gidx] = 1'b1;
      rsp_rdata       = rdata_q;
      rsp_err         = err_q;
    end
  end

  // Transfer FSM with registered APB outputs; reset aborts any transfer in flight.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state   <= IDLE;
      last    <= IDX_W'(NREQ - 1);
      gidx    <= '0;
      tcnt    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      PSEL    <= 1'b0;
      PENABLE <= 1'b0;
      PWRITE  <= 1'b0;
      PADDR   <= '0;
      PWDATA  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            gidx   <= grant_idx;
            last   <= grant_idx;
            PSEL   <= 1'b1;
            PWRITE <= sel_write;
            PADDR  <= sel_addr;
            PWDATA <= sel_wdata;
            state  <= SETUP;
          end
        end
        SETUP: begin
          PENABLE <= 1'b1;
          tcnt    <= '0;
          state   <= ACCESS;
        end
        ACCESS: begin
          // PREADY wins over the watchdog when both happen in the same cycle.
          if (PREADY || (tcnt == TCNT_LAST)) begin
            rdata_q <= (PREADY && !PWRITE) ? PRDATA : '0;
            err_q   <= !PREADY;
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            PWRITE  <= 1'b0;
            PADDR   <= '0;
            PWDATA  <= '0;
            state   <= RESP;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_poli_apb_arbiter.sv
// Directed testbench for poli_apb_arbiter (NREQ=2, DATA_W=32, TIMEOUT=8).
// Inputs change 1ns after the rising edge; outputs are compared mid-cycle.
module tb_poli_apb_arbiter;

  localparam int NREQ = 2;
  localparam int DW   = 32;
  localparam int TO   = 8;
  localparam logic [DW-1:0] NAND_NOR_CONTROL_ADDR = 32'h0000_0004;
  localparam logic [DW-1:0] CRC_STATUS_ADDR       = 32'h0000_0020;

  logic                 CLK = 1'b0;
  logic                 nRST = 1'b0;
  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ-1:0]      req_write = '0;
  logic [NREQ*DW-1:0]   req_addr = '0;
  logic [NREQ*DW-1:0]   req_wdata = '0;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ-1:0]      rsp_valid;
  logic [DW-1:0]        rsp_rdata;
  logic                 rsp_err;
  logic                 PSEL, PENABLE, PWRITE;
  logic [DW-1:0]        PADDR, PWDATA;
  logic [DW-1:0]        PRDATA = '0;
  logic                 PREADY = 1'b0;

  int n_cmp  = 0;
  int n_fail = 0;

  poli_apb_arbiter #(.NREQ(NREQ), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .CLK(CLK), .nRST(nRST),
    .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY)
  );

  always #5 CLK = ~CLK;

  // Advance to 1ns after the next rising edge (input drive point).
  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  // Advance from the drive point to the middle of the cycle (sample point).
  task automatic mid();
    #4;
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    req_valid = '0;
    PREADY = 1'b0;
    PRDATA = '0;
    next_cycle();
    next_cycle();
    nRST = 1'b1;
    next_cycle();
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    req_valid = 2'b11;
    #3;
    n_cmp++;
    if ({req_ready, rsp_valid, rsp_err, PSEL, PENABLE, PWRITE} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b required 00000000",
               {req_ready, rsp_valid, rsp_err, PSEL, PENABLE, PWRITE});
    end
    n_cmp++;
    if ({PADDR, PWDATA, rsp_rdata} !== 96'h0) begin
      n_fail++;
      $display("FAIL reset_data: got %h required 0", {PADDR, PWDATA, rsp_rdata});
    end
    req_valid = '0;
    next_cycle();
    nRST = 1'b1;
    next_cycle();
    $display("test_reset done: cmp=%0d fail=%0d", n_cmp, n_fail);
  endtask

  task automatic test_single_write();
    PREADY = 1'b1;
    req_valid = 2'b01;
    req_write = 2'b01;
    req_addr[0 +: DW] = NAND_NOR_CONTROL_ADDR;
    req_wdata[0 +: DW] = 32'h1;
    mid();
    n_cmp++;
    if ({req_ready, PSEL} !== 3'b010) begin
      n_fail++;
      $display("FAIL wr_T: ready/psel got %b required 010", {req_ready, PSEL});
    end
    next_cycle();
    req_valid = '0;
    mid();
    n_cmp++;
    if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA} !== {3'b101, NAND_NOR_CONTROL_ADDR, 32'h1}) begin
      n_fail++;
      $display("FAIL wr_T1: got %b %h %h required 101 %h 1",
               {PSEL, PENABLE, PWRITE}, PADDR, PWDATA, NAND_NOR_CONTROL_ADDR);
    end
    next_cycle();
    mid();
    n_cmp++;
    if ({PSEL, PENABLE, rsp_valid} !== 4'b1100) begin
      n_fail++;
      $display("FAIL wr_T2: psel/pen/rsp got %b required 1100", {PSEL, PENABLE, rsp_valid});
    end
    next_cycle();
    mid();
    n_cmp++;
    if ({rsp_valid, rsp_err, rsp_rdata, PSEL, PENABLE} !== {2'b01, 1'b0, 32'h0, 2'b00}) begin
      n_fail++;
      $display("FAIL wr_T3: rsp_valid=%b err=%b rdata=%h psel=%b required 01 0 0 0",
               rsp_valid, rsp_err, rsp_rdata, PSEL);
    end
    next_cycle();
    mid();
    n_cmp++;
    if ({rsp_valid, rsp_err, rsp_rdata, PSEL} !== 36'h0) begin
      n_fail++;
      $display("FAIL wr_T4: rsp_valid=%b rdata=%h psel=%b required idle", rsp_valid, rsp_rdata, PSEL);
    end
    next_cycle();
    req_write = '0;
    $display("test_single_write done: cmp=%0d fail=%0d", n_cmp, n_fail);
  endtask

  task automatic test_contention();
    logic [1:0] exp_rdy, exp_rsp;
    do_reset();
    PREADY = 1'b1;
    req_write = 2'b11;
    req_addr = {32'h0000_0111, 32'h0000_0100};
    req_wdata = {32'hBBBB_0001, 32'hAAAA_0000};
    req_valid = 2'b11;
    for (int i = 0; i <= 16; i++) begin
      exp_rdy = 2'b00;
      exp_rsp = 2'b00;
      if (i <= 12 && i % 4 == 0) exp_rdy = ((i / 4) % 2 == 0) ? 2'b01 : 2'b10;
      if (i >= 3 && i % 4 == 3) exp_rsp = (((i - 3) / 4) % 2 == 0) ? 2'b01 : 2'b10;
      mid();
      n_cmp++;
      if ({req_ready, rsp_valid} !== {exp_rdy, exp_rsp}) begin
        n_fail++;
        $display("FAIL contention_c%0d: ready=%b rsp=%b required ready=%b rsp=%b",
                 i, req_ready, rsp_valid, exp_rdy, exp_rsp);
      end
      if (i % 4 == 1) begin
        n_cmp++;
        if (PADDR !== (((i / 4) % 2 == 0) ? 32'h0000_0100 : 32'h0000_0111)) begin
          n_fail++;
          $display("FAIL contention_addr_c%0d: PADDR=%h", i, PADDR);
        end
      end
      next_cycle();
      if (i == 12) req_valid = 2'b00;
    end
    req_write = '0;
    $display("test_contention done: cmp=%0d fail=%0d", n_cmp, n_fail);
  endtask

  task automatic test_read_wait();
    PREADY = 1'b0;
    req_write = 2'b00;
    req_addr[DW +: DW] = CRC_STATUS_ADDR;
    req_valid = 2'b10;
    for (int i = 0; i <= 7; i++) begin
      if (i == 5) begin
        PREADY = 1'b1;
        PRDATA = 32'h1;
      end
      mid();
      if (i == 0) begin
        n_cmp++;
        if (req_ready !== 2'b10) begin
          n_fail++;
          $display("FAIL rd_ready: got %b required 10", req_ready);
        end
      end else if (i >= 1 && i <= 5) begin
        n_cmp++;
        if ({PSEL, PENABLE, PWRITE, PADDR, rsp_valid} !==
            {1'b1, (i >= 2), 1'b0, CRC_STATUS_ADDR, 2'b00}) begin
          n_fail++;
          $display("FAIL rd_apb_c%0d: ctl=%b addr=%h rsp=%b required %b %h 00",
                   i, {PSEL, PENABLE, PWRITE}, PADDR, rsp_valid, {1'b1, (i >= 2), 1'b0}, CRC_STATUS_ADDR);
        end
      end else if (i == 6) begin
        n_cmp++;
        if ({rsp_valid, rsp_err, rsp_rdata, PSEL} !== {2'b10, 1'b0, 32'h1, 1'b0}) begin
          n_fail++;
          $display("FAIL rd_rsp: rsp=%b err=%b rdata=%h psel=%b required 10 0 00000001 0",
                   rsp_valid, rsp_err, rsp_rdata, PSEL);
        end
      end else begin
        n_cmp++;
        if ({rsp_valid, rsp_rdata} !== 34'h0) begin
          n_fail++;
          $display("FAIL rd_after: rsp=%b rdata=%h required 0", rsp_valid, rsp_rdata);
        end
      end
      next_cycle();
      if (i == 0) req_valid = '0;
      if (i == 5) begin
        PREADY = 1'b0;
        PRDATA = '0;
      end
    end
    $display("test_read_wait done: cmp=%0d fail=%0d", n_cmp, n_fail);
  endtask

  task automatic test_timeout();
    int psel_cycles;
    psel_cycles = 0;
    PREADY = 1'b0;
    req_write = 2'b01;
    req_valid = 2'b01;
    for (int i = 0; i <= 11; i++) begin
      mid();
      if (PSEL === 1'b1) psel_cycles++;
      if (i == 9) begin
        n_cmp++;
        if ({PSEL, PENABLE, rsp_valid, rsp_err} !== 5'b11000) begin
          n_fail++;
          $display("FAIL to_last_access: ctl=%b rsp=%b err=%b required 11 00 0",
                   {PSEL, PENABLE}, rsp_valid, rsp_err);
        end
      end
      if (i == 10) begin
        n_cmp++;
        if ({rsp_valid, rsp_err, rsp_rdata, PSEL, PENABLE} !== {2'b01, 1'b1, 32'h0, 2'b00}) begin
          n_fail++;
          $display("FAIL to_rsp: rsp=%b err=%b rdata=%h psel=%b required 01 1 0 0",
                   rsp_valid, rsp_err, rsp_rdata, PSEL);
        end
      end
      if (i == 11) begin
        n_cmp++;
        if ({rsp_valid, rsp_err, PSEL, PENABLE, PADDR} !== 37'h0) begin
          n_fail++;
          $display("FAIL to_idle: rsp=%b err=%b psel=%b paddr=%h required idle",
                   rsp_valid, rsp_err, PSEL, PADDR);
        end
      end
      next_cycle();
      if (i == 0) req_valid = '0;
    end
    n_cmp++;
    if (psel_cycles !== TO + 1) begin
      n_fail++;
      $display("FAIL to_psel_len: got %0d cycles required %0d", psel_cycles, TO + 1);
    end
    req_write = '0;
    $display("test_timeout done: cmp=%0d fail=%0d", n_cmp, n_fail);
  endtask

  task automatic test_ready_at_limit();
    PREADY = 1'b0;
    req_write = 2'b00;
    req_valid = 2'b10;
    for (int i = 0; i <= 10; i++) begin
      if (i == 9) begin
        PREADY = 1'b1;
        PRDATA = 32'hA5;
      end
      mid();
      if (i == 10) begin
        n_cmp++;
        if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 1'b0, 32'hA5}) begin
          n_fail++;
          $display("FAIL limit_rsp: rsp=%b err=%b rdata=%h required 10 0 000000a5",
                   rsp_valid, rsp_err, rsp_rdata);
        end
      end
      next_cycle();
      if (i == 0) req_valid = '0;
      if (i == 9) begin
        PREADY = 1'b0;
        PRDATA = '0;
      end
    end
    $display("test_ready_at_limit done: cmp=%0d fail=%0d", n_cmp, n_fail);
  endtask

  task automatic test_reset_mid_access();
    int rsp_seen;
    rsp_seen = 0;
    PREADY = 1'b0;
    req_write = 2'b01;
    req_valid = 2'b01;
    next_cycle();
    req_valid = '0;
    next_cycle();
    next_cycle();
    mid();
    n_cmp++;
    if ({PSEL, PENABLE} !== 2'b11) begin
      n_fail++;
      $display("FAIL rst_pre: psel/pen got %b required 11", {PSEL, PENABLE});
    end
    nRST = 1'b0;
    #1;
    n_cmp++;
    if ({PSEL, PENABLE, rsp_valid, req_ready} !== 6'b0) begin
      n_fail++;
      $display("FAIL rst_async: psel/pen/rsp/rdy got %b required 000000",
               {PSEL, PENABLE, rsp_valid, req_ready});
    end
    req_valid = 2'b11;
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      if (rsp_valid !== 2'b00) rsp_seen++;
    end
    nRST = 1'b1;
    PREADY = 1'b1;
    for (int i = 0; i <= 4; i++) begin
      mid();
      if (i == 0) begin
        n_cmp++;
        if (req_ready !== 2'b01) begin
          n_fail++;
          $display("FAIL rst_first_grant: got %b required 01", req_ready);
        end
      end
      if (i == 3) begin
        n_cmp++;
        if (rsp_valid !== 2'b01) begin
          n_fail++;
          $display("FAIL rst_first_rsp: got %b required 01", rsp_valid);
        end
      end
      if (i == 4) begin
        n_cmp++;
        if (req_ready !== 2'b10) begin
          n_fail++;
          $display("FAIL rst_second_grant: got %b required 10", req_ready);
        end
      end
      if (i < 3 && rsp_valid !== 2'b00) rsp_seen++;
      next_cycle();
      if (i == 0) req_valid = 2'b10;
      if (i == 4) req_valid = 2'b00;
    end
    n_cmp++;
    if (rsp_seen !== 0) begin
      n_fail++;
      $display("FAIL rst_no_rsp: saw %0d spurious rsp_valid cycles required 0", rsp_seen);
    end
    for (int i = 0; i < 4; i++) next_cycle();
    PREADY = 1'b0;
    $display("test_reset_mid_access done: cmp=%0d fail=%0d", n_cmp, n_fail);
  endtask

  initial begin
    #1;
    test_reset();
    test_single_write();
    test_contention();
    test_read_wait();
    test_timeout();
    test_ready_at_limit();
    test_reset_mid_access();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
